// File: rtl/window_loader_pkg.sv
// Shared types and helpers for the serial-to-parallel window loader.
// State encoding and the counter width function live here.
package window_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        HOLD = 2'b10
    } state_t;

    function automatic int cw_of(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/window_loader_if.sv
// Handshake bundle between a serial source / window consumer and the loader.
// The abort line exists only when WINDOW_LOADER_ABORT_EN is defined.
interface window_loader_if
    import window_loader_pkg::*;
#(
    parameter int N  = 5,
    parameter int CW = cw_of(N)
);
    logic          start;
    logic          in_valid;
    logic          in_bit;
    logic          in_ready;
    logic [N-1:0]  win;
    logic          win_valid;
    logic          win_ack;
    logic [CW-1:0] count;
`ifdef WINDOW_LOADER_ABORT_EN
    logic          abort;
`endif

    modport master (
        output start, in_valid, in_bit, win_ack,
`ifdef WINDOW_LOADER_ABORT_EN
        output abort,
`endif
        input  in_ready, win, win_valid, count
    );

    modport slave (
        input  start, in_valid, in_bit, win_ack,
`ifdef WINDOW_LOADER_ABORT_EN
        input  abort,
`endif
        output in_ready, win, win_valid, count
    );

endinterface

// File: rtl/window_loader_bit_counter.sv
// Saturation-free bit counter for the loader; clear wins over enable.
// The FSM guarantees enable never fires once count reaches N.
module bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count
);

    // count accepted bits, restarting on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/window_loader.sv
// Shifts N serial bits into a parallel window and holds it until acked.
// Optional abort input enabled by WINDOW_LOADER_ABORT_EN.
module window_loader
    import window_loader_pkg::*;
#(
    parameter int N  = 5,
    parameter int CW = cw_of(N)
) (
    input logic            clk,
    input logic            rst,
    window_loader_if.slave bus
);

    state_t       state;
    state_t       state_nx;
    logic         clr;
    logic         acc;
    logic         last;
    logic         kill;
    logic [N-1:0] win;

`ifdef WINDOW_LOADER_ABORT_EN
    assign kill = bus.abort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign acc  = (state == LOAD) && bus.in_valid && !kill;
    assign last = (bus.count == CW'(N - 1));

    assign bus.in_ready  = (state == LOAD);
    assign bus.win_valid = (state == HOLD);
    assign bus.win       = win;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state decode and window/counter clear request
    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = LOAD;
                    clr      = 1'b1;
                end
            end
            LOAD: begin
                if (acc && last)
                    state_nx = HOLD;
            end
            HOLD: begin
                if (bus.win_ack) begin
                    if (bus.start) begin
                        state_nx = LOAD;
                        clr      = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (kill) begin
            state_nx = IDLE;
            clr      = 1'b1;
        end
    end

    generate
        if (N == 1) begin : g_one
            // single-bit window just captures the bit
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    win <= '0;
                else if (clr)
                    win <= '0;
                else if (acc)
                    win <= bus.in_bit;
            end
        end else begin : g_shift
            // shift left so the first accepted bit lands at the MSB
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    win <= '0;
                else if (clr)
                    win <= '0;
                else if (acc)
                    win <= {win[N-2:0], bus.in_bit};
            end
        end
    endgenerate

    bit_counter #(
        .CW(CW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .enable(acc),
        .count (bus.count)
    );

endmodule

// File: tb/tb_window_loader.sv
// Directed bench for window_loader (N=5) with a window scoreboard.
// Abort scenarios compile in when WINDOW_LOADER_ABORT_EN is defined.
module tb_window_loader;

    localparam int N  = 5;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [N-1:0] sb[$];

    window_loader_if #(.N(N), .CW(CW)) bus ();

    window_loader #(.N(N), .CW(CW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_load(input logic [N-1:0] exp);
        sb.push_back(exp);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("load_ready", bus.in_ready, 1);
        chk("load_cnt0", bus.count, 0);
        chk("load_win0", bus.win, 0);
    endtask

    task automatic take_win(input string tag);
        logic [N-1:0] e;
        chk({tag, "_valid"}, bus.win_valid, 1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_win"}, bus.win, e);
            chk({tag, "_cnt"}, bus.count, N);
            chk({tag, "_rdy"}, bus.in_ready, 0);
        end
    endtask

    task automatic send_all(input logic [N-1:0] w);
        for (int i = N - 1; i >= 0; i--) begin
            send(w[i]);
            if (i > 0) begin
                chk("mid_cnt", bus.count, N - i);
                chk("mid_valid", bus.win_valid, 0);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.win_ack  = 1'b0;
`ifdef WINDOW_LOADER_ABORT_EN
        bus.abort    = 1'b0;
`endif
        step();
        step();
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_valid", bus.win_valid, 0);
        chk("rst_cnt", bus.count, 0);
        chk("rst_win", bus.win, 0);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        chk("idle_stay", bus.in_ready, 0);
        chk("idle_cnt", bus.count, 0);

        // all ones, consecutive
        begin_load(5'b11111);
        send_all(5'b11111);
        take_win("ones");
        bus.win_ack = 1'b1;
        step();
        bus.win_ack = 1'b0;
        chk("ones_ack_valid", bus.win_valid, 0);
        chk("ones_ack_keep", bus.win, 5'b11111);

        // 1,0, gap x2, 1,1,0
        begin_load(5'b10110);
        send(1'b1);
        send(1'b0);
        for (int g = 0; g < 2; g++) begin
            bus.in_bit = g[0];
            step();
            chk("gap_cnt", bus.count, 2);
            chk("gap_win", bus.win, 5'b00010);
        end
        send(1'b1);
        send(1'b1);
        chk("gap_pre_valid", bus.win_valid, 0);
        send(1'b0);
        take_win("gap");

        // hold with in_valid high and no ack
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.in_bit = c[0];
            bus.start  = c[1];
            step();
            chk("hold_rdy", bus.in_ready, 0);
            chk("hold_win", bus.win, 5'b10110);
            chk("hold_valid", bus.win_valid, 1);
            chk("hold_cnt", bus.count, N);
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.win_ack  = 1'b1;
        step();
        bus.win_ack  = 1'b0;
        chk("hold_ack_valid", bus.win_valid, 0);
        chk("hold_ack_rdy", bus.in_ready, 0);
        chk("hold_ack_keep", bus.win, 5'b10110);

        // ack + start in the same hold cycle
        begin_load(5'b01011);
        send_all(5'b01011);
        take_win("alt");
        bus.win_ack = 1'b1;
        bus.start   = 1'b1;
        step();
        bus.win_ack = 1'b0;
        bus.start   = 1'b0;
        chk("restart_rdy", bus.in_ready, 1);
        chk("restart_win", bus.win, 0);
        chk("restart_cnt", bus.count, 0);
        chk("restart_valid", bus.win_valid, 0);

        // reset mid-load
        send(1'b1);
        send(1'b0);
        send(1'b1);
        chk("pre_rst_cnt", bus.count, 3);
        chk("pre_rst_win", bus.win, 5'b00101);
        rst = 1'b1;
        #1;
        chk("arst_rdy", bus.in_ready, 0);
        chk("arst_cnt", bus.count, 0);
        chk("arst_win", bus.win, 0);
        chk("arst_valid", bus.win_valid, 0);
        step();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        step();
        step();
        bus.in_valid = 1'b0;
        chk("post_rst_idle", bus.in_ready, 0);
        chk("post_rst_cnt", bus.count, 0);
        begin_load(5'b11001);
        send_all(5'b11001);
        take_win("resume");
        bus.win_ack = 1'b1;
        step();
        bus.win_ack = 1'b0;

`ifdef WINDOW_LOADER_ABORT_EN
        // abort after two bits
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        send(1'b1);
        send(1'b1);
        chk("ab_pre_cnt", bus.count, 2);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        chk("ab_load_rdy", bus.in_ready, 0);
        chk("ab_load_win", bus.win, 0);
        chk("ab_load_cnt", bus.count, 0);

        // abort beats ack and start in hold
        begin_load(5'b10101);
        send_all(5'b10101);
        take_win("ab_hold");
        bus.abort   = 1'b1;
        bus.win_ack = 1'b1;
        bus.start   = 1'b1;
        step();
        bus.abort   = 1'b0;
        bus.win_ack = 1'b0;
        bus.start   = 1'b0;
        chk("ab_hold_rdy", bus.in_ready, 0);
        chk("ab_hold_win", bus.win, 0);
        chk("ab_hold_valid", bus.win_valid, 0);
        chk("ab_hold_cnt", bus.count, 0);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
